// File: rtl/per2axi_resp_tracker.sv
// Response stage of the peripheral-to-AXI bridge: rebuilds 32-bit peripheral responses from AXI R/B beats.
// Optional pending-entry consistency checking is enabled by defining PER2AXI_RESP_ERRCHK_EN.
module per2axi_resp_tracker #(
  parameter int PER_ID_WIDTH   = 5,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_USER_WIDTH = 6,
  parameter int AXI_ID_WIDTH   = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_i,

  input  logic                      trans_req_i,
  input  logic [AXI_ID_WIDTH-1:0]   trans_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0] trans_add_i,
  input  logic                      atop_req_i,
  input  logic [AXI_ID_WIDTH-1:0]   atop_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0] atop_add_i,

  input  logic                      axi_master_r_valid_i,
  input  logic [AXI_DATA_WIDTH-1:0] axi_master_r_data_i,
  input  logic [1:0]                axi_master_r_resp_i,
  input  logic                      axi_master_r_last_i,
  input  logic [AXI_ID_WIDTH-1:0]   axi_master_r_id_i,
  input  logic [AXI_USER_WIDTH-1:0] axi_master_r_user_i,
  output logic                      axi_master_r_ready_o,

  input  logic                      axi_master_b_valid_i,
  input  logic [1:0]                axi_master_b_resp_i,
  input  logic [AXI_ID_WIDTH-1:0]   axi_master_b_id_i,
  input  logic [AXI_USER_WIDTH-1:0] axi_master_b_user_i,
  output logic                      axi_master_b_ready_o,

  output logic                      per_slave_r_valid_o,
  output logic                      per_slave_r_opc_o,
  output logic [PER_ID_WIDTH-1:0]   per_slave_r_id_o,
  output logic [31:0]               per_slave_r_rdata_o,

  output logic                      resp_err_o
);

  localparam int NUM_IDS = 1 << AXI_ID_WIDTH;

  logic [NUM_IDS-1:0] hi_q, hi_d;
  logic [NUM_IDS-1:0] rd_pend_q, rd_pend_d;
  logic [NUM_IDS-1:0] atop_pend_q, atop_pend_d;

  logic r_fire, b_fire, b_silent, b_resp;

  logic                    rsp_valid_d, rsp_valid_q;
  logic                    rsp_opc_d, rsp_opc_q;
  logic [PER_ID_WIDTH-1:0] rsp_id_d, rsp_id_q;
  logic [31:0]             rsp_rdata_d, rsp_rdata_q;

  // AXI IDs beyond the peripheral ID width map to an all-zero ID.
  function automatic logic [PER_ID_WIDTH-1:0] id_to_onehot(input logic [AXI_ID_WIDTH-1:0] id);
    logic [PER_ID_WIDTH-1:0] oh;
    oh = '0;
    for (int i = 0; i < PER_ID_WIDTH; i++) oh[i] = (int'(id) == i);
    return oh;
  endfunction

  assign b_silent = atop_pend_q[axi_master_b_id_i];

  assign axi_master_r_ready_o = !rst_i;
  assign axi_master_b_ready_o = !rst_i && (!axi_master_r_valid_i || b_silent);

  assign r_fire = axi_master_r_valid_i && axi_master_r_ready_o;
  assign b_fire = axi_master_b_valid_i && axi_master_b_ready_o;
  // A response-producing B can only fire when R is idle, so it never competes with R.
  assign b_resp = b_fire && !b_silent;

  // Clears from this cycle's handshakes first, then notification sets override them.
  always_comb begin
    // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latch).
    hi_d        = hi_q;
    rd_pend_d   = rd_pend_q;
    atop_pend_d = atop_pend_q;
    if (r_fire)              rd_pend_d[axi_master_r_id_i]   = 1'b0;
    if (b_fire && b_silent)  atop_pend_d[axi_master_b_id_i] = 1'b0;
    if (trans_req_i) begin
      rd_pend_d[trans_id_i] = 1'b1;
      hi_d[trans_id_i]      = trans_add_i[2];
    end
    if (atop_req_i) begin
      atop_pend_d[atop_id_i] = 1'b1;
      rd_pend_d[atop_id_i]   = 1'b1;
      hi_d[atop_id_i]        = atop_add_i[2];
    end
  end

`ifdef PER2AXI_RESP_ERRCHK_EN
  logic err_d, err_q;
`endif

  always_comb begin
    rsp_valid_d = 1'b0;
    rsp_opc_d   = 1'b0;
    rsp_id_d    = '0;
    rsp_rdata_d = '0;
`ifdef PER2AXI_RESP_ERRCHK_EN
    err_d       = 1'b0;
`endif
    if (r_fire) begin
      rsp_valid_d = 1'b1;
      rsp_opc_d   = axi_master_r_resp_i[1];
      rsp_id_d    = id_to_onehot(axi_master_r_id_i);
      rsp_rdata_d = hi_q[axi_master_r_id_i] ? axi_master_r_data_i[63:32]
                                            : axi_master_r_data_i[31:0];
`ifdef PER2AXI_RESP_ERRCHK_EN
      if (!rd_pend_q[axi_master_r_id_i]) begin
        rsp_opc_d = 1'b1;
        err_d     = 1'b1;
      end
`endif
    end else if (b_resp) begin
      rsp_valid_d = 1'b1;
      rsp_opc_d   = axi_master_b_resp_i[1];
      rsp_id_d    = id_to_onehot(axi_master_b_id_i);
      // SC semantics: EXOKAY reports success (0), anything else reports failure (1).
      rsp_rdata_d = {31'b0, axi_master_b_resp_i != 2'b01};
`ifdef PER2AXI_RESP_ERRCHK_EN
      // atop_pend is known clear on this path; a pending read on a write ID is inconsistent.
      if (rd_pend_q[axi_master_b_id_i]) begin
        rsp_opc_d = 1'b1;
        err_d     = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hi_q        <= '0;
      rd_pend_q   <= '0;
      atop_pend_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_opc_q   <= 1'b0;
      rsp_id_q    <= '0;
      rsp_rdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      hi_q        <= hi_d;
      rd_pend_q   <= rd_pend_d;
      atop_pend_q <= atop_pend_d;
      rsp_valid_q <= rsp_valid_d;
      if (rsp_valid_d) begin
        rsp_opc_q   <= rsp_opc_d;
        rsp_id_q    <= rsp_id_d;
        rsp_rdata_q <= rsp_rdata_d;
      end
    end
  end

`ifdef PER2AXI_RESP_ERRCHK_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_q | err_d;
  end
  assign resp_err_o = err_q;
`else
  assign resp_err_o = 1'b0;
`endif

  assign per_slave_r_valid_o = rsp_valid_q;
  assign per_slave_r_opc_o   = rsp_opc_q;
  assign per_slave_r_id_o    = rsp_id_q;
  assign per_slave_r_rdata_o = rsp_rdata_q;

  logic unused_ok;
  assign unused_ok = &{1'b0, axi_master_r_last_i, axi_master_r_user_i, axi_master_b_user_i,
                       trans_add_i, atop_add_i, axi_master_r_data_i, rd_pend_q};

endmodule

// File: tb/tb_per2axi_resp_tracker.sv
// Scoreboard bench for per2axi_resp_tracker: directed scenarios, random traffic and mid-transaction reset
// against a per-ID pending-state model.
module tb_per2axi_resp_tracker;

  localparam int PW = 5;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int UW = 6;
  localparam int IW = 3;
  localparam int N  = 1 << IW;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          trans_req_i = 1'b0, atop_req_i = 1'b0;
  logic [IW-1:0] trans_id_i = '0, atop_id_i = '0;
  logic [AW-1:0] trans_add_i = '0, atop_add_i = '0;
  logic          r_valid = 1'b0, r_last = 1'b1, r_ready;
  logic [DW-1:0] r_data = '0;
  logic [1:0]    r_resp = '0, b_resp = '0;
  logic [IW-1:0] r_id = '0, b_id = '0;
  logic [UW-1:0] r_user = '0, b_user = '0;
  logic          b_valid = 1'b0, b_ready;
  logic          p_valid, p_opc, resp_err;
  logic [PW-1:0] p_id;
  logic [31:0]   p_rdata;

  per2axi_resp_tracker #(
    .PER_ID_WIDTH(PW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
    .AXI_USER_WIDTH(UW), .AXI_ID_WIDTH(IW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .trans_req_i(trans_req_i), .trans_id_i(trans_id_i), .trans_add_i(trans_add_i),
    .atop_req_i(atop_req_i), .atop_id_i(atop_id_i), .atop_add_i(atop_add_i),
    .axi_master_r_valid_i(r_valid), .axi_master_r_data_i(r_data), .axi_master_r_resp_i(r_resp),
    .axi_master_r_last_i(r_last), .axi_master_r_id_i(r_id), .axi_master_r_user_i(r_user),
    .axi_master_r_ready_o(r_ready),
    .axi_master_b_valid_i(b_valid), .axi_master_b_resp_i(b_resp), .axi_master_b_id_i(b_id),
    .axi_master_b_user_i(b_user), .axi_master_b_ready_o(b_ready),
    .per_slave_r_valid_o(p_valid), .per_slave_r_opc_o(p_opc),
    .per_slave_r_id_o(p_id), .per_slave_r_rdata_o(p_rdata),
    .resp_err_o(resp_err)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          due;
    bit          opc;
    bit [PW-1:0] id;
    bit [31:0]   rdata;
    bit          err;
  } exp_t;

  typedef struct {
    bit tr; int tid; bit [31:0] tadd;
    bit ar; int aid; bit [31:0] aadd;
    bit rv; bit [63:0] rdat; bit [1:0] rr; int rid;
    bit bv; bit [1:0] br; int bid;
  } stim_t;

  exp_t exp_q[$];
  bit   m_hi[N], m_rd[N], m_at[N];
  bit   m_err;
  int   cyc = 0;
  int   n_checks = 0, n_fail = 0;

  always @(posedge clk_i) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit [PW-1:0] m_onehot(input int id);
    bit [PW-1:0] one;
    one = 1;
    return (id < PW) ? (one << id) : '0;
  endfunction

  function automatic stim_t idle_stim();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_hi[i] = 1'b0; m_rd[i] = 1'b0; m_at[i] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  // One clock cycle of stimulus; predictions use the model state before this cycle's updates.
  task automatic drive(input stim_t s, output bit b_fired);
    exp_t e;
    bit   b_silent;
    @(posedge clk_i); #1;
    trans_req_i = s.tr; trans_id_i = IW'(s.tid); trans_add_i = s.tadd;
    atop_req_i  = s.ar; atop_id_i  = IW'(s.aid); atop_add_i  = s.aadd;
    r_valid = s.rv; r_data = s.rdat; r_resp = s.rr; r_id = IW'(s.rid);
    b_valid = s.bv; b_resp = s.br; b_id = IW'(s.bid);
    #1;
    b_silent = m_at[s.bid];
    check("r_ready", 64'(r_ready), 64'(1));
    check("b_ready", 64'(b_ready), 64'(!s.rv || b_silent));
    b_fired = s.bv && (!s.rv || b_silent);
    if (s.rv) begin
      e.due   = cyc + 1;
      e.id    = m_onehot(s.rid);
      e.rdata = m_hi[s.rid] ? s.rdat[63:32] : s.rdat[31:0];
      e.opc   = s.rr[1];
`ifdef PER2AXI_RESP_ERRCHK_EN
      if (!m_rd[s.rid]) begin e.opc = 1'b1; m_err = 1'b1; end
`endif
      e.err = m_err;
      exp_q.push_back(e);
    end else if (b_fired && !b_silent) begin
      e.due   = cyc + 1;
      e.id    = m_onehot(s.bid);
      e.rdata = (s.br == 2'b01) ? 32'd0 : 32'd1;
      e.opc   = s.br[1];
`ifdef PER2AXI_RESP_ERRCHK_EN
      if (m_rd[s.bid]) begin e.opc = 1'b1; m_err = 1'b1; end
`endif
      e.err = m_err;
      exp_q.push_back(e);
    end
    if (s.rv) m_rd[s.rid] = 1'b0;
    if (b_fired && b_silent) m_at[s.bid] = 1'b0;
    if (s.tr) begin m_rd[s.tid] = 1'b1; m_hi[s.tid] = s.tadd[2]; end
    if (s.ar) begin m_at[s.aid] = 1'b1; m_rd[s.aid] = 1'b1; m_hi[s.aid] = s.aadd[2]; end
  endtask

  task automatic idle(input int n);
    bit f;
    repeat (n) drive(idle_stim(), f);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    r_valid = 1'b1; b_valid = 1'b1; trans_req_i = 1'b0; atop_req_i = 1'b0;
    repeat (n) begin
      @(negedge clk_i);
      check("rst_r_ready", 64'(r_ready), 64'(0));
      check("rst_b_ready", 64'(b_ready), 64'(0));
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0; r_valid = 1'b0; b_valid = 1'b0;
    model_clear();
    exp_q.delete();
    @(negedge clk_i);
    check("rst_valid", 64'(p_valid), 64'(0));
    check("rst_opc",   64'(p_opc),   64'(0));
    check("rst_id",    64'(p_id),    64'(0));
    check("rst_rdata", 64'(p_rdata), 64'(0));
    check("rst_err",   64'(resp_err), 64'(0));
  endtask

  // Monitor: every non-reset cycle either a due response is checked or valid must be low.
  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_i) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        check("rsp_valid", 64'(p_valid), 64'(1));
        check("rsp_opc",   64'(p_opc),   64'(e.opc));
        check("rsp_id",    64'(p_id),    64'(e.id));
        check("rsp_rdata", 64'(p_rdata), 64'(e.rdata));
        check("rsp_err",   64'(resp_err), 64'(e.err));
      end else begin
        check("idle_valid", 64'(p_valid), 64'(0));
      end
    end
  end

  initial begin
    stim_t s;
    bit    f;
    bit    hold_b;
    model_clear();
    do_reset(3);

    // Read upper word
    s = idle_stim(); s.tr = 1; s.tid = 2; s.tadd = 32'h1000_0004; drive(s, f);
    s = idle_stim(); s.rv = 1; s.rid = 2; s.rdat = 64'hAAAA_BBBB_CCCC_DDDD; s.rr = 2'b00; drive(s, f);
    idle(1);
    @(negedge clk_i);
    check("tp_read_valid", 64'(p_valid), 64'(1));
    check("tp_read_rdata", 64'(p_rdata), 64'hAAAA_BBBB);
    check("tp_read_id",    64'(p_id),    64'b00100);
    check("tp_read_opc",   64'(p_opc),   64'(0));

    // Plain write with SLVERR
    s = idle_stim(); s.bv = 1; s.bid = 1; s.br = 2'b10; drive(s, f);
    idle(1);
    @(negedge clk_i);
    check("tp_wr_opc",   64'(p_opc),   64'(1));
    check("tp_wr_id",    64'(p_id),    64'b00010);
    check("tp_wr_rdata", 64'(p_rdata), 64'(1));

    // Atomic: B consumed silently, R returns the lower word
    s = idle_stim(); s.ar = 1; s.aid = 3; s.aadd = 32'h2000_0000; drive(s, f);
    s = idle_stim(); s.bv = 1; s.bid = 3; s.br = 2'b00; drive(s, f);
    check("tp_atop_b_fired", 64'(f), 64'(1));
    idle(1);
    @(negedge clk_i);
    check("tp_atop_b_silent", 64'(p_valid), 64'(0));
    s = idle_stim(); s.rv = 1; s.rid = 3; s.rdat = 64'h7; drive(s, f);
    idle(1);
    @(negedge clk_i);
    check("tp_atop_r_rdata", 64'(p_rdata), 64'(7));

    // R and response-producing B collide: R first, B held and completed next cycle
    s = idle_stim(); s.rv = 1; s.rid = 0; s.rdat = 64'h1234_5678_9ABC_DEF0;
    s.bv = 1; s.bid = 4; s.br = 2'b00; drive(s, f);
    @(negedge clk_i);
    check("tp_arb_b_ready", 64'(b_ready), 64'(0));
    s = idle_stim(); s.bv = 1; s.bid = 4; s.br = 2'b00; drive(s, f);
    @(negedge clk_i);
    check("tp_arb_first_id", 64'(p_id), 64'h01);
    idle(1);
    @(negedge clk_i);
    check("tp_arb_second_id", 64'(p_id), 64'h10);

    // SC-style B back to back: EXOKAY then OKAY
    s = idle_stim(); s.bv = 1; s.bid = 1; s.br = 2'b01; drive(s, f);
    s.br = 2'b00; drive(s, f);
    @(negedge clk_i);
    check("tp_sc_exokay", 64'(p_rdata), 64'(0));
    idle(1);
    @(negedge clk_i);
    check("tp_sc_okay", 64'(p_rdata), 64'(1));

    // R for an ID with no pending entry (ID 6 maps to an all-zero peripheral ID)
    s = idle_stim(); s.rv = 1; s.rid = 6; s.rdat = 64'h5; drive(s, f);
    idle(1);
    @(negedge clk_i);
    check("tp_nopend_id", 64'(p_id), 64'(0));
`ifdef PER2AXI_RESP_ERRCHK_EN
    check("tp_nopend_opc", 64'(p_opc), 64'(1));
    idle(3);
    @(negedge clk_i);
    check("tp_err_sticky", 64'(resp_err), 64'(1));
`else
    check("tp_nopend_opc", 64'(p_opc), 64'(0));
    check("tp_err_tied", 64'(resp_err), 64'(0));
`endif

    // Random traffic; a stalled B beat is held stable until accepted
    hold_b = 1'b0;
    s = idle_stim();
    for (int i = 0; i < 1500; i++) begin
      s.tr = ($urandom_range(3) == 0); s.tid = int'($urandom_range(N - 1)); s.tadd = $urandom;
      s.ar = ($urandom_range(5) == 0); s.aid = int'($urandom_range(N - 1)); s.aadd = $urandom;
      s.rv = ($urandom_range(1) == 0); s.rid = int'($urandom_range(N - 1));
      s.rdat = {$urandom, $urandom}; s.rr = 2'($urandom_range(3));
      if (!hold_b) begin
        s.bv = ($urandom_range(1) == 0); s.bid = int'($urandom_range(N - 1));
        s.br = 2'($urandom_range(3));
      end
      drive(s, f);
      hold_b = s.bv && !f;
    end
    idle(2);

    // Reset with pending atomic and read: entries are dropped
    s = idle_stim(); s.ar = 1; s.aid = 5; s.aadd = 32'h4; drive(s, f);
    s = idle_stim(); s.tr = 1; s.tid = 7; s.tadd = 32'h4; drive(s, f);
    idle(1);
    do_reset(2);
    s = idle_stim(); s.bv = 1; s.bid = 5; s.br = 2'b00; drive(s, f);
    idle(1);
    @(negedge clk_i);
    check("post_rst_b_not_silent", 64'(p_valid), 64'(1));
    check("post_rst_b_rdata", 64'(p_rdata), 64'(1));
    s = idle_stim(); s.rv = 1; s.rid = 7; s.rdat = 64'hFFFF_0000_1111_2222; drive(s, f);
    idle(1);
    @(negedge clk_i);
    check("post_rst_r_low_word", 64'(p_rdata), 64'h1111_2222);

    idle(3);
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/per2axi_resp_tracker.md
# per2axi_resp_tracker

Response stage of the peripheral-to-AXI bridge. It sits downstream of the request channel and consumes the AXI4 R and B channels. It uses the request channel's `trans_*` and `atop_*` notifications to rebuild single 32-bit peripheral-interconnect responses: word-lane select, one-hot ID, error opcode, and suppression of redundant atomic B beats. It has a per-ID tracking table and a registered response port with fixed R-over-B arbitration.

## Interface
Parameters:
- `PER_ID_WIDTH`, 5: width of the one-hot peripheral ID.
- `AXI_ADDR_WIDTH`, 32: width of the notified address.
- `AXI_DATA_WIDTH`, 64: R data width. Fixed at 64.
- `AXI_USER_WIDTH`, 6: R and B user width. Accepted, not used.
- `AXI_ID_WIDTH`, 3: AXI ID width. The table has 2^AXI_ID_WIDTH entries.

Ports:
- Clocking and reset. One clock; reset is synchronous and active-high.
  - `clk_i` in, 1: clock.
  - `rst_i` in, 1: synchronous active-high reset.
- Request-channel notifications.
  - `trans_req_i` in, 1: a read was issued this cycle.
  - `trans_id_i` in, AXI_ID_WIDTH: AXI ID of that read.
  - `trans_add_i` in, AXI_ADDR_WIDTH: address of that read.
  - `atop_req_i` in, 1: an atomic returning R data was issued this cycle.
  - `atop_id_i` in, AXI_ID_WIDTH: AXI ID of that atomic.
  - `atop_add_i` in, AXI_ADDR_WIDTH: address of that atomic.
- AXI R channel.
  - `axi_master_r_valid_i` in, 1: R beat valid.
  - `axi_master_r_data_i` in, 64: R data.
  - `axi_master_r_resp_i` in, 2: R response.
  - `axi_master_r_last_i` in, 1: last beat. Always 1; ignored.
  - `axi_master_r_id_i` in, AXI_ID_WIDTH: R ID.
  - `axi_master_r_user_i` in, AXI_USER_WIDTH: unused.
  - `axi_master_r_ready_o` out, 1: R ready.
- AXI B channel.
  - `axi_master_b_valid_i` in, 1: B beat valid.
  - `axi_master_b_resp_i` in, 2: B response.
  - `axi_master_b_id_i` in, AXI_ID_WIDTH: B ID.
  - `axi_master_b_user_i` in, AXI_USER_WIDTH: unused.
  - `axi_master_b_ready_o` out, 1: B ready.
- Peripheral response port.
  - `per_slave_r_valid_o` out, 1: response valid. Single-cycle pulse.
  - `per_slave_r_opc_o` out, 1: 1 means error.
  - `per_slave_r_id_o` out, PER_ID_WIDTH: one-hot requester ID.
  - `per_slave_r_rdata_o` out, 32: response data.
- `resp_err_o` out, 1: sticky error for a response with no pending entry.

## Operation
- Table entry, per AXI ID:
  - `hi`: holds addr[2].
  - `rd_pend`.
  - `atop_pend`.
- Notifications:
  - `trans_req_i` sets `rd_pend` and `hi` for `trans_id_i`.
  - `atop_req_i` sets `atop_pend`, `rd_pend` and `hi` for `atop_id_i`.
  - Both notifications in the same cycle for different IDs update both entries. For the same ID, `atop_req_i` wins.
- R handshake:
  - `axi_master_r_ready_o` = !rst_i. The response register can always accept.
  - On R handshake: rdata = `hi` ? data[63:32] : data[31:0]; opc = resp[1]; clear `rd_pend`.
- B handshake:
  - If `atop_pend` is set for the ID, the beat is consumed silently (no peripheral response) and `atop_pend` is cleared.
  - Otherwise a response is produced: opc = resp[1]; rdata = {31'b0, resp != 2'b01}. This yields SC fail=1 on OKAY and success=0 on EXOKAY; plain writes ignore rdata.
- Arbitration:
  - `axi_master_b_ready_o` = !rst_i && (!axi_master_r_valid_i || B is silent).
  - A response-producing B is stalled while R is valid. R has priority; a silent B may complete in the same cycle as R.
- ID mapping: `per_slave_r_id_o` = 1 << axi_id. If axi_id ≥ PER_ID_WIDTH, the ID is all-zero.
- Same-cycle table write and response lookup for the same ID: the lookup uses the pre-update entry. The write takes effect next cycle, and the clear from the response is overridden by the set.

## Timing
- Latency: the response is registered. `per_slave_r_valid_o` is high in the cycle after the AXI handshake, for exactly 1 cycle. Back-to-back handshakes give back-to-back pulses.
- Outputs hold their last data while valid is low. Only valid is guaranteed low when idle.
- Reset values:
  - `per_slave_r_valid_o`, `per_slave_r_opc_o`, `per_slave_r_id_o`, `per_slave_r_rdata_o`: 0.
  - `resp_err_o`: 0.
  - Table: all flags cleared.
  - Both ready outputs: 0 while `rst_i` is high.
- Reset mid-transaction: pending entries are dropped. A response arriving after reset is treated as having no pending entry.

## Configuration
- `PER2AXI_RESP_ERRCHK_EN` defined:
  - An R with `rd_pend`=0 forces opc=1.
  - A non-silent B for an ID with `rd_pend` or `atop_pend` inconsistent also forces opc=1.
  - Either case sets `resp_err_o`, which stays set until reset.
- Undefined: no pending check; opc comes from resp only; `resp_err_o` is tied to 0.

## Test plan
- Read at 0x1000_0004, ID 2 (`trans_req_i`), then R ID 2 with data 0xAAAA_BBBB_CCCC_DDDD, resp OKAY → the next cycle shows valid=1, rdata=0xAAAA_BBBB, id=5'b00100, opc=0.
- Plain write: B ID 1, resp SLVERR → valid=1, opc=1, id=5'b00010, rdata=1.
- Atomic ADD, ID 3 (`atop_req_i`, address bit2=0), then B ID 3 then R ID 3 with data 0x0000_0000_0000_0007 → B gets no response; the R response has rdata=7.
- R ID 0 and a response-producing B ID 4 valid in the same cycle → b_ready=0 that cycle. Responses follow in consecutive cycles, id 0x01 then 0x10.
- SC-style B ID 1 with resp EXOKAY → rdata=0. With resp OKAY → rdata=1.
- With `PER2AXI_RESP_ERRCHK_EN`, an R for ID 6 with no pending entry → opc=1 and `resp_err_o`=1, held until `rst_i`.
